bitmap_pixel_streamer: RTL and testbench
========================================

# bitmap_pixel_streamer

Reads the 135×80 one-bit board bitmap produced by the static image source and serialises it into a row-major pixel stream with a valid/ready handshake and frame/line markers. It sits between the board image source and the display driver's pixel pipeline, and is the consumer end of the bitmap interface. Each row is latched into a local buffer before it is streamed, so the source may change between rows without corrupting the row in flight.

## Interface
- `WIDTH`, default 135: pixels per row, equal to the bits per row word.
- `HEIGHT`, default 80: rows per frame.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `image` in [WIDTH-1:0] [0:HEIGHT-1]: bitmap input.
  - Row 0 is the top row.
  - Bit WIDTH-1 of a row word is pixel x=0 (leftmost).
- `start` in 1: request one frame scan. Sampled only in IDLE.
- `abort` in 1: terminate the scan in progress.
- `pix_valid` out 1: a pixel beat is presented.
- `pix_ready` in 1: the downstream consumer accepts the beat.
- `pix_data` out 1: pixel value (1 = lit).
- `pix_x` out $clog2(WIDTH) (8): column of the current beat.
- `pix_y` out $clog2(HEIGHT) (7): row of the current beat.
- `pix_sof` out 1: marks the beat at x=0, y=0.
- `pix_eol` out 1: marks the beat at x=WIDTH-1.
- `pix_eof` out 1: marks the beat at x=WIDTH-1, y=HEIGHT-1.
- `busy` out 1: high in every state other than IDLE.
- `done` out 1: one-cycle pulse when a frame completes normally.

## Operation
- States and transitions:
  - IDLE → LOAD on `start` && !`abort`.
  - LOAD → STREAM.
  - STREAM → LOAD after the last beat of a row that is not the final row.
  - STREAM → DONE after the last beat of row HEIGHT-1.
  - DONE → IDLE.
  - Any state → IDLE on `abort`, unless already in IDLE.
- LOAD:
  - `row_buf` ← `image[y]`.
  - `x` ← 0.
  - `pix_valid` is 0 during LOAD (one bubble per row).
- STREAM:
  - `pix_valid`=1.
  - `pix_data` = `row_buf[WIDTH-1-x]`.
  - A beat completes when `pix_valid` && `pix_ready`; `x` then increments.
  - At x=WIDTH-1 a completed beat wraps `x` to 0 and increments `y`.
- Backpressure: while `pix_valid` && !`pix_ready`, `pix_data`, `pix_x`, `pix_y` and the markers hold stable.
- Markers are combinational from `x`, `y` and state, and are gated by `pix_valid`.
- DONE: `done`=1 for exactly one cycle; `busy` is still 1.
- `start` is ignored while `busy`=1. `start` held high in IDLE after DONE launches the next frame immediately.
- Abort:
  - Next state is IDLE and `pix_valid` drops on the next edge.
  - No `done` is produced; `x` and `y` clear.
  - `abort` and `start` together in IDLE: abort wins, no scan.
- Changes on `image` during STREAM affect only rows that have not yet been loaded.

## Timing
- Reset values: `pix_valid`, `pix_data`, `pix_x`, `pix_y`, `pix_sof`, `pix_eol`, `pix_eof`, `busy` and `done` are all 0. State is IDLE.
- Reset mid-frame clears the frame immediately (asynchronous). No resume after reset.
- `start` sampled at edge E:
  - LOAD occupies cycle E+1.
  - The first beat is valid in cycle E+2.
- Each row costs 1 + (WIDTH beats + stall cycles).
- With `pix_ready` held at 1, `done` is high HEIGHT·(WIDTH+1)+1 cycles after E. For 135×80 that is 10881 cycles.
- Total beats per frame: WIDTH·HEIGHT = 10800.

## Structure
- Package `bitmap_pkg` holds:
  - `IMG_WIDTH`=135, `IMG_HEIGHT`=80.
  - `IMG_XW`=8, `IMG_YW`=7.
  - The state enum `scan_state_t` {IDLE, LOAD, STREAM, DONE}.
  - The row typedef `img_row_t` = logic [IMG_WIDTH-1:0].
- One sub-module, `scan_counter`: the x/y wrap counters.
  - Inputs: clear, advance, width, height.
  - Outputs: x, y, last_col, last_row.
- The FSM, `row_buf` and the output mux remain in the top module.

## Test plan
- Board image, `pix_ready`=1, pulse `start` → exactly 10800 beats in order:
  - row 0 is all 0;
  - row 1 is x=0..25 =1, x=26 =0, x=27..52 =1, x=53 =0;
  - `done` arrives at E+10881.
- Row 26 → x=0..81 =0, x=82..107 =1, x=108 =0. Row 79 → x=82..134 =0.
- Random `pix_ready` at 30% duty:
  - beat stream identical to the `pix_ready`=1 case;
  - outputs stable while stalled;
  - `sof`/`eol`/`eof` appear once each on (0,0), each x=134, and (134,79).
- `abort` at beat (40,12) → `pix_valid`=0 on the next cycle, no `done`, `busy`=0. A new `start` then begins again at (0,0).
- `start` pulsed mid-frame → ignored. `start` and `abort` together in IDLE → stays IDLE.
- Modify `image[5]` while row 5 is streaming → row 5 output unchanged; row 6 reflects updates applied before its LOAD.
- Assert `rst_n` low at beat (100,60) → all outputs 0 asynchronously, and the state is IDLE after release.

Source files
------------

// File: rtl/bitmap_pkg.sv
// Shared dimensions and types for the board bitmap pixel streamer.
// The default geometry matches the 135x80 board image.
package bitmap_pkg;

    localparam int IMG_WIDTH  = 135;
    localparam int IMG_HEIGHT = 80;
    localparam int IMG_XW     = 8;
    localparam int IMG_YW     = 7;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STREAM,
        DONE
    } scan_state_t;

    typedef logic [IMG_WIDTH-1:0] img_row_t;

endpackage

// File: rtl/bitmap_pixel_streamer_scan_counter.sv
// Column/row wrap counters for the raster scan.
// x runs 0..width-1; y advances on each column wrap and wraps after the last row.
module scan_counter
    import bitmap_pkg::*;
#(
    parameter int XW = IMG_XW,
    parameter int YW = IMG_YW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          advance,
    input  logic [XW:0]   width,
    input  logic [YW:0]   height,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last_col,
    output logic          last_row
);

    // One extra bit on width/height so a power-of-two dimension still fits.
    assign last_col = ({1'b0, x} == (width - (XW+1)'(1)));
    assign last_row = ({1'b0, y} == (height - (YW+1)'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else if (clear) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (last_col) begin
                x <= '0;
                y <= last_row ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bitmap_pixel_streamer.sv
// Serialises the one-bit board bitmap into a row-major valid/ready pixel stream
// with frame/line markers. Each row is latched before streaming.
//
//   state  | meaning
//   IDLE   | waiting for start; counters held clear
//   LOAD   | latch image[y] into row_buf (one bubble per row)
//   STREAM | present row_buf pixels, one per accepted beat
//   DONE   | one-cycle frame-complete pulse
module bitmap_pixel_streamer
    import bitmap_pkg::*;
#(
    parameter int WIDTH  = IMG_WIDTH,
    parameter int HEIGHT = IMG_HEIGHT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [WIDTH-1:0]          image [0:HEIGHT-1],
    input  logic                      start,
    input  logic                      abort,
    output logic                      pix_valid,
    input  logic                      pix_ready,
    output logic                      pix_data,
    output logic [$clog2(WIDTH)-1:0]  pix_x,
    output logic [$clog2(HEIGHT)-1:0] pix_y,
    output logic                      pix_sof,
    output logic                      pix_eol,
    output logic                      pix_eof,
    output logic                      busy,
    output logic                      done
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);

    scan_state_t      state;
    scan_state_t      state_next;
    logic [WIDTH-1:0] row_buf;
    logic [XW-1:0]    x;
    logic [YW-1:0]    y;
    logic             last_col;
    logic             last_row;
    logic             beat;
    logic             cnt_clear;

    scan_counter #(
        .XW (XW),
        .YW (YW)
    ) u_scan_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (cnt_clear),
        .advance  (beat),
        .width    ((XW+1)'(WIDTH)),
        .height   ((YW+1)'(HEIGHT)),
        .x        (x),
        .y        (y),
        .last_col (last_col),
        .last_row (last_row)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (start && !abort) state_next = LOAD;
            LOAD:   state_next = STREAM;
            STREAM: if (beat && last_col) state_next = last_row ? DONE : LOAD;
            DONE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // Abort overrides every transition; in IDLE it simply blocks start.
        if (abort && (state != IDLE)) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_buf <= '0;
        end else if (state == LOAD) begin
            row_buf <= image[y];
        end
    end

    assign cnt_clear = (state == IDLE) || abort;
    assign beat      = pix_valid && pix_ready;

    // Bit WIDTH-1 of the row word is the leftmost pixel.
    assign pix_valid = (state == STREAM);
    assign pix_data  = pix_valid && row_buf[XW'(WIDTH-1) - x];
    assign pix_x     = x;
    assign pix_y     = y;
    assign pix_sof   = pix_valid && (x == '0) && (y == '0);
    assign pix_eol   = pix_valid && last_col;
    assign pix_eof   = pix_valid && last_col && last_row;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_bitmap_pixel_streamer.sv
// Scoreboard bench for bitmap_pixel_streamer: expected beats are queued when a
// frame is launched and consumed as the DUT hands beats over.
module tb_bitmap_pixel_streamer;
    import bitmap_pkg::*;

    localparam int W = IMG_WIDTH;
    localparam int H = IMG_HEIGHT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        pix_ready = 1'b0;
    logic        pix_valid, pix_data, pix_sof, pix_eol, pix_eof, busy, done;
    logic [7:0]  pix_x;
    logic [6:0]  pix_y;
    img_row_t    img [0:H-1];

    int          n_tests = 0;
    int          n_fail = 0;
    logic [18:0] sb [$];
    bit          rand_ready = 1'b0;
    int          sof_cnt, eol_cnt, eof_cnt;
    bit          stalled = 1'b0;
    logic [18:0] held;

    bitmap_pixel_streamer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .image     (img),
        .start     (start),
        .abort     (abort),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_data  (pix_data),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_sof   (pix_sof),
        .pix_eol   (pix_eol),
        .pix_eof   (pix_eof),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [18:0] pack_beat(input bit d, input int x, input int y);
        return {d, 8'(x), 7'(y), 1'(x == 0 && y == 0), 1'(x == W-1), 1'(x == W-1 && y == H-1)};
    endfunction

    task automatic fill_image();
        logic [159:0] t;
        for (int r = 0; r < H; r++) begin
            t = {$urandom, $urandom, $urandom, $urandom, $urandom};
            img[r] = (r == 0) ? '0 : t[W-1:0];
        end
    endtask

    task automatic push_frame(input bit use_ovr, input img_row_t ovr6);
        img_row_t row;
        for (int r = 0; r < H; r++) begin
            row = (use_ovr && r == 6) ? ovr6 : img[r];
            for (int c = 0; c < W; c++) sb.push_back(pack_beat(row[W-1-c], c, r));
        end
        sof_cnt = 0;
        eol_cnt = 0;
        eof_cnt = 0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < limit) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic wait_beat(input int bx, input int by, input int limit, output bit found);
        found = 1'b0;
        for (int i = 0; i < limit && !found; i++) begin
            @(negedge clk);
            if (pix_valid && pix_x == 8'(bx) && pix_y == 7'(by)) found = 1'b1;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            pix_ready = rand_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
        end
    end

    always @(negedge clk) begin
        logic [18:0] cur;
        if (!rst_n) begin
            stalled = 1'b0;
        end else if (pix_valid) begin
            cur = {pix_data, pix_x, pix_y, pix_sof, pix_eol, pix_eof};
            if (stalled) check("stall_hold", 32'(cur), 32'(held));
            if (pix_ready) begin
                check("sb_nonempty", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) check("beat", 32'(cur), 32'(sb.pop_front()));
                sof_cnt += int'(pix_sof);
                eol_cnt += int'(pix_eol);
                eof_cnt += int'(pix_eof);
            end
            stalled = !pix_ready;
            held = cur;
        end else begin
            check("gated_out", 32'({pix_data, pix_sof, pix_eol, pix_eof}), 0);
            stalled = 1'b0;
        end
    end

    initial begin
        int cyc;
        bit found;
        img_row_t new5, new6;
        logic [159:0] t;

        fill_image();
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", pix_valid, 0);
        check("rst_data", pix_data, 0);
        check("rst_x", pix_x, 0);
        check("rst_y", pix_y, 0);
        check("rst_markers", {pix_sof, pix_eol, pix_eof}, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clk) rst_n = 1'b1;

        // Full frame, no backpressure: latency and beat order.
        push_frame(1'b0, '0);
        pulse_start();
        check("load_bubble", pix_valid, 0);
        check("load_busy", busy, 1);
        wait_done(12000, cyc);
        check("done_latency", cyc + 1, 10881);
        check("f1_drained", sb.size(), 0);
        check("f1_sof", sof_cnt, 1);
        check("f1_eol", eol_cnt, H);
        check("f1_eof", eof_cnt, 1);
        check("f1_done_busy", busy, 1);
        @(posedge clk); #1;
        check("done_one_cycle", done, 0);
        check("idle_after_done", busy, 0);

        // Random backpressure at ~30% ready duty.
        fill_image();
        rand_ready = 1'b1;
        push_frame(1'b0, '0);
        pulse_start();
        wait_done(50000, cyc);
        check("rand_done", done, 1);
        check("rand_drained", sb.size(), 0);
        check("rand_sof", sof_cnt, 1);
        check("rand_eol", eol_cnt, H);
        check("rand_eof", eof_cnt, 1);
        rand_ready = 1'b0;
        @(posedge clk); #1;

        // Abort at beat (40,12).
        push_frame(1'b0, '0);
        pulse_start();
        wait_beat(40, 12, 3000, found);
        check("reach_40_12", found, 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_valid", pix_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_xy", {pix_x, pix_y}, 0);
        sb.delete();
        repeat (3) begin
            @(posedge clk); #1;
            check("abort_no_done", done, 0);
        end

        // start together with abort in IDLE stays idle.
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_idle", busy, 0);
        @(posedge clk); #1;
        check("start_abort_idle2", busy, 0);

        // Image edits while row 5 streams; a mid-frame start must be ignored.
        t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        new6 = t[W-1:0];
        new5 = ~img[5];
        push_frame(1'b1, new6);
        pulse_start();
        wait_beat(10, 5, 2000, found);
        check("reach_10_5", found, 1);
        img[5] = new5;
        img[6] = new6;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("mid_start_busy", busy, 1);
        wait_done(12000, cyc);
        check("mod_done", done, 1);
        check("mod_drained", sb.size(), 0);
        @(posedge clk); #1;

        // Asynchronous reset at beat (100,60).
        push_frame(1'b0, '0);
        pulse_start();
        wait_beat(100, 60, 9000, found);
        check("reach_100_60", found, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", pix_valid, 0);
        check("arst_data", pix_data, 0);
        check("arst_xy", {pix_x, pix_y}, 0);
        check("arst_markers", {pix_sof, pix_eol, pix_eof}, 0);
        check("arst_busy_done", {busy, done}, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_idle", {busy, pix_valid, done}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
